// File: rtl/sr_pkg.sv
// Shared encodings for the RS latch command driver: command opcodes and FSM states.
package sr_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_FORBID = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RELEASE = 2'd2,
    CHECK   = 2'd3
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async level through two flops; both clear to 0 on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// Command-side driver for a cross-coupled RS latch. Turns HOLD/SET/RESET commands
// into fixed-width r/s pulses, lets the latch settle, then checks the synchronized
// q/nq against the expected state and records sticky errors.
//
// Handshake: a command is taken on a rising edge where cmd_valid & cmd_ready.
// cmd_ready is high only in IDLE; cmd_valid seen in any other state is dropped,
// nothing is queued. done pulses for exactly the one CHECK cycle of each command.
module sr_latch_driver
  import sr_pkg::*;
#(
  parameter int HOLD_CYCLES   = 10,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       r,
  output logic       s,
  input  logic       q,
  input  logic       nq,
  output logic       done,
  output logic       q_exp,
  output logic       err_mismatch,
  output logic       err_illegal,
  input  logic       err_clear,
  output state_t     state_dbg
);

  localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          q_exp_valid;
  logic          chk_en;
  logic          q_sync;
  logic          nq_sync;
  logic          accept;
  logic          chk_fail;
  logic          new_mismatch;
  logic          new_illegal;

  sync2 u_sync_q (
    .clk (clk),
    .rst (rst),
    .d   (q),
    .q   (q_sync)
  );

  sync2 u_sync_nq (
    .clk (clk),
    .rst (rst),
    .d   (nq),
    .q   (nq_sync)
  );

  assign accept       = cmd_valid & cmd_ready;
  assign chk_fail     = (q_sync != q_exp) | (q_sync == nq_sync);
  assign new_mismatch = (state == CHECK) & chk_en & q_exp_valid & chk_fail;
  assign new_illegal  = accept & (cmd_op == OP_FORBID);
  assign state_dbg    = state;

  // Command FSM: r and s are only ever set from IDLE with the other forced low,
  // and both clear together on the DRIVE->RELEASE edge, so r&s never overlaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      r           <= 1'b0;
      s           <= 1'b0;
      done        <= 1'b0;
      cmd_ready   <= 1'b1;
      q_exp       <= 1'b0;
      q_exp_valid <= 1'b0;
      chk_en      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            case (cmd_op)
              OP_SET: begin
                state       <= DRIVE;
                s           <= 1'b1;
                r           <= 1'b0;
                cnt         <= HOLD_LD;
                q_exp       <= 1'b1;
                q_exp_valid <= 1'b1;
                chk_en      <= 1'b1;
              end
              OP_RESET: begin
                state       <= DRIVE;
                r           <= 1'b1;
                s           <= 1'b0;
                cnt         <= HOLD_LD;
                q_exp       <= 1'b0;
                q_exp_valid <= 1'b1;
                chk_en      <= 1'b1;
              end
              OP_HOLD: begin
                state  <= RELEASE;
                cnt    <= SETTLE_LD;
                chk_en <= 1'b1;
              end
              default: begin
                // Forbidden op: nothing is driven and nothing is compared.
                state  <= CHECK;
                done   <= 1'b1;
                chk_en <= 1'b0;
              end
            endcase
          end
        end
        DRIVE: begin
          if (cnt == CNT_ONE) begin
            state <= RELEASE;
            r     <= 1'b0;
            s     <= 1'b0;
            cnt   <= SETTLE_LD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        RELEASE: begin
          if (cnt == CNT_ONE) begin
            state <= CHECK;
            done  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        CHECK: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          r         <= 1'b0;
          s         <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as err_clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_mismatch <= 1'b0;
      err_illegal  <= 1'b0;
    end else begin
      err_mismatch <= new_mismatch | (err_mismatch & ~err_clear);
      err_illegal  <= new_illegal  | (err_illegal  & ~err_clear);
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: behavioural RS latch on r/s/q/nq, randomized commands,
// expected results pushed per command and checked by an independent monitor.
module tb_sr_latch_driver;
  import sr_pkg::*;

  localparam int HOLD   = 10;
  localparam int SETTLE = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       r;
  logic       s;
  logic       q;
  logic       nq;
  logic       done;
  logic       q_exp;
  logic       err_mismatch;
  logic       err_illegal;
  logic       err_clear;
  state_t     state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sr_latch_driver #(
    .HOLD_CYCLES   (HOLD),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_ready    (cmd_ready),
    .r            (r),
    .s            (s),
    .q            (q),
    .nq           (nq),
    .done         (done),
    .q_exp        (q_exp),
    .err_mismatch (err_mismatch),
    .err_illegal  (err_illegal),
    .err_clear    (err_clear),
    .state_dbg    (state_dbg)
  );

  // ---------------- behavioural RS latch ----------------
  logic lq    = 1'b0;
  logic stuck = 1'b0;
  always @(r or s) begin
    if (s && !r) lq = 1'b1;
    else if (r && !s) lq = 1'b0;
  end
  assign q  = stuck ? 1'b0 : lq;
  assign nq = stuck ? 1'b1 : ~lq;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what the latch should hold and what the flags should read.
  bit m_q_exp = 0;
  bit m_valid = 0;
  bit m_mis   = 0;
  bit m_ill   = 0;
  bit m_lq    = 0;
  bit m_stuck = 0;

  // ---------------- monitor ----------------
  bit          err_pending = 0;
  logic [31:0] cur;

  always @(negedge clk) begin
    if (err_pending) begin
      check("err_mismatch_after_cmd", int'(err_mismatch), int'(cur[1]));
      check("err_illegal_after_cmd", int'(err_illegal), int'(cur[0]));
      err_pending = 0;
    end
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        check("done_cycle", cyc & 16'hffff, int'(cur[31:16]));
        check("q_exp_at_done", int'(q_exp), int'(cur[2]));
        check("cmd_ready_low_at_done", int'(cmd_ready), 0);
        err_pending = 1;
      end
    end
  end

  // Every cycle: no r/s overlap, and each completed pulse is exactly HOLD wide.
  int s_run = 0;
  int r_run = 0;
  always @(negedge clk) begin
    check("r_and_s_never", int'(r & s), 0);
    if (rst) begin
      s_run = 0;
      r_run = 0;
    end else begin
      if (s) s_run++;
      else begin
        if (s_run != 0) check("s_pulse_width", s_run, HOLD);
        s_run = 0;
      end
      if (r) r_run++;
      else begin
        if (r_run != 0) check("r_pulse_width", r_run, HOLD);
        r_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
  endtask

  // Issue one command (optionally with a same-cycle err_clear) and return one
  // negedge after its done pulse, when the driver is idle again.
  task automatic issue(input logic [1:0] op, input bit clr);
    int  t_acc;
    int  lat;
    int  n;
    bit  cmp;
    bit  obs_q;
    bit  obs_nq;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    err_clear = clr;
    t_acc     = cyc + 1;
    if (clr) begin
      m_mis = 0;
      m_ill = 0;
    end
    cmp = 0;
    lat = 1;
    case (op)
      OP_SET:   begin m_q_exp = 1; m_valid = 1; m_lq = 1; lat = 1 + HOLD + SETTLE; cmp = 1; end
      OP_RESET: begin m_q_exp = 0; m_valid = 1; m_lq = 0; lat = 1 + HOLD + SETTLE; cmp = 1; end
      OP_HOLD:  begin lat = 1 + SETTLE; cmp = m_valid; end
      default:  begin lat = 1; cmp = 0; m_ill = 1; end
    endcase
    obs_q  = m_stuck ? 1'b0 : m_lq;
    obs_nq = m_stuck ? 1'b1 : ~m_lq;
    if (cmp && ((obs_q != m_q_exp) || (obs_q == obs_nq))) m_mis = 1;
    exp_q.push_back({16'(t_acc + lat - 1), 13'd0, m_q_exp, m_mis, m_ill});
    @(negedge clk);
    err_clear = 1'b0;
    cmd_valid = 1'b0;
    // While busy, throw random commands at the DUT; they must be ignored.
    n = 0;
    while (!done && n < 100) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom_range(0, 3));
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    if (!done) begin
      check("done_timeout", 0, 1);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    m_mis = 0;
    m_ill = 0;
    check("err_mismatch_cleared", int'(err_mismatch), 0);
    check("err_illegal_cleared", int'(err_illegal), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_HOLD;
    err_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_r", int'(r), 0);
    check("rst_s", int'(s), 0);
    check("rst_done", int'(done), 0);
    check("rst_q_exp", int'(q_exp), 0);
    check("rst_err_mismatch", int'(err_mismatch), 0);
    check("rst_err_illegal", int'(err_illegal), 0);
    check("rst_state", int'(state_dbg), int'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Directed walk: HOLD from reset, SET, RESET, HOLD, FORBIDDEN, clear.
    issue(OP_HOLD, 0);
    issue(OP_SET, 0);
    check("latch_q_after_set", int'(q), 1);
    issue(OP_RESET, 0);
    issue(OP_HOLD, 0);
    check("latch_q_after_hold", int'(q), 0);
    issue(OP_FORBID, 0);
    clear_errs();

    // Stuck latch output: SET must flag, and the flag must survive a good command.
    stuck   = 1'b1;
    m_stuck = 1;
    issue(OP_SET, 0);
    stuck   = 1'b0;
    m_stuck = 0;
    issue(OP_RESET, 0);
    clear_errs();

    // Error and clear arriving together: the new error wins.
    issue(OP_FORBID, 1);

    // Randomized commands, occasional stuck output and clears.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      bit         clr;
      op  = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) begin
        stuck   = 1'b1;
        m_stuck = 1;
      end
      issue(op, clr);
      stuck   = 1'b0;
      m_stuck = 0;
      if ($urandom_range(0, 5) == 0) clear_errs();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the 5th DRIVE cycle of a SET: pulse dies, command is lost.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = OP_SET;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("s_high_before_rst", int'(s), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_drive_s", int'(s), 0);
    check("rst_mid_drive_r", int'(r), 0);
    m_lq    = 1;
    m_q_exp = 0;
    m_valid = 0;
    m_mis   = 0;
    m_ill   = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", int'(cmd_ready), 1);
    check("q_exp_after_rst", int'(q_exp), 0);
    check("err_mismatch_after_rst", int'(err_mismatch), 0);
    repeat (20) @(negedge clk);
    check("no_pending_after_rst", exp_q.size(), 0);

    // A good HOLD after the aborted SET: not compared (no expected state yet).
    issue(OP_HOLD, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
